// File: rtl/aes_pkg.sv
// Shared AES-128 types and constants for the key-schedule engine and its
// neighbours in the cipher datapath.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    FIN  = 2'd2
  } key_exp_state_t;

endpackage

// File: rtl/key_round.sv
// One AES-128 key-schedule step: SubWord(RotWord(w3)) ^ rcon, then the XOR chain.
module key_round
  import aes_pkg::*;
(
  input  logic [127:0] cur_key,
  input  logic [7:0]   rcon,
  output logic [127:0] next_key
);

  word_t w0, w1, w2, w3;
  word_t rot_w, sub_w, t_w;
  word_t n0, n1, n2, n3;

  assign w0 = cur_key[127:96];
  assign w1 = cur_key[95:64];
  assign w2 = cur_key[63:32];
  assign w3 = cur_key[31:0];

  assign rot_w = {w3[23:0], w3[31:24]};

  sbox u_sbox0 (.in_byte(rot_w[31:24]), .out_byte(sub_w[31:24]));
  sbox u_sbox1 (.in_byte(rot_w[23:16]), .out_byte(sub_w[23:16]));
  sbox u_sbox2 (.in_byte(rot_w[15:8]),  .out_byte(sub_w[15:8]));
  sbox u_sbox3 (.in_byte(rot_w[7:0]),   .out_byte(sub_w[7:0]));

  assign t_w = sub_w ^ {rcon, 24'h000000};

  // Each new word depends on the freshly computed previous one.
  assign n0 = w0 ^ t_w;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/rcon.sv
// AES round-constant lookup; entries past the last AES-128 round read as zero.
module rcon (
  input  logic [3:0] idx,
  output logic [7:0] rcon_byte
);

  always_comb begin
    rcon_byte = 8'h00;
    case (idx)
      4'd0:    rcon_byte = 8'h01;
      4'd1:    rcon_byte = 8'h02;
      4'd2:    rcon_byte = 8'h04;
      4'd3:    rcon_byte = 8'h08;
      4'd4:    rcon_byte = 8'h10;
      4'd5:    rcon_byte = 8'h20;
      4'd6:    rcon_byte = 8'h40;
      4'd7:    rcon_byte = 8'h80;
      4'd8:    rcon_byte = 8'h1b;
      4'd9:    rcon_byte = 8'h36;
      default: rcon_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/sbox.sv
// AES forward S-box: one byte substitution, purely combinational table lookup.
module sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Row r holds S(16r) .. S(16r+15), first entry in the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777b_f26b6fc5_3001672b_fed7ab76,
    128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
    128'hb7fd9326_363ff7cc_34a5e5f1_71d83115,
    128'h04c723c3_1896059a_071280e2_eb27b275,
    128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84,
    128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
    128'hd0efaafb_434d3385_45f9027f_503c9fa8,
    128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
    128'hcd0c13ec_5f974417_c4a77e3d_645d1973,
    128'h60814fdc_222a9088_46eeb814_de5e0bdb,
    128'he0323a0a_4906245c_c2d3ac62_9195e479,
    128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
    128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a,
    128'h703eb566_4803f60e_613557b9_86c11d9e,
    128'he1f89811_69d98e94_9b1e87e9_ce5528df,
    128'h8ca1890d_bfe64268_41992d0f_b054bb16
  };

  logic [10:0] bit_pos;

  assign bit_pos  = 11'd2047 - {in_byte, 3'b000};
  assign out_byte = SBOX_TABLE[bit_pos -: 8];

endmodule

// File: rtl/key_expander.sv
// Iterative AES-128 key schedule: emits round keys 0..10 over valid/ready,
// computing one round per accepted key.
module key_expander
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         key_ready,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         key_valid,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  key_exp_state_t state_q, state_d;
  block_t         cur_key_q, cur_key_d;
  logic [3:0]     round_idx_q, round_idx_d;
  logic           key_valid_q, key_valid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [3:0]     rcon_idx;
  logic [7:0]     rcon_byte;
  block_t         next_key;

  // Round 10 never feeds the next-key logic, so keep the table inside 0..9.
  assign rcon_idx = (round_idx_q == LAST_ROUND) ? 4'd0 : round_idx_q;

  rcon u_rcon (
    .idx       (rcon_idx),
    .rcon_byte (rcon_byte)
  );

  key_round u_key_round (
    .cur_key  (cur_key_q),
    .rcon     (rcon_byte),
    .next_key (next_key)
  );

  always_comb begin
    state_d     = state_q;
    cur_key_d   = cur_key_q;
    round_idx_d = round_idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = EMIT;
          cur_key_d   = key_in;
          round_idx_d = 4'd0;
        end
      end
      EMIT: begin
        if (key_ready) begin
          if (round_idx_q == LAST_ROUND) begin
            state_d = FIN;
          end else begin
            cur_key_d   = next_key;
            round_idx_d = round_idx_q + 4'd1;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered copies of what the next state implies.
    key_valid_d = (state_d == EMIT);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == FIN);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      cur_key_q   <= '0;
      round_idx_q <= 4'd0;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_key_q   <= cur_key_d;
      round_idx_q <= round_idx_d;
      key_valid_q <= key_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign round_key = cur_key_q;
  assign round_idx = round_idx_q;
  assign key_valid = key_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_key_expander.sv
// Self-checking bench for key_expander: FIPS-197 key schedule model computed
// from GF(2^8) arithmetic, compared against every valid round key.
module tb_key_expander;

  logic         clk;
  logic         n_rst;
  logic         start;
  logic [127:0] key_in;
  logic         key_ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_valid;
  logic         busy;
  logic         done;

  key_expander dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .key_in    (key_in),
    .key_ready (key_ready),
    .round_key (round_key),
    .round_idx (round_idx),
    .key_valid (key_valid),
    .busy      (busy),
    .done      (done)
  );

  localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_Z   = 128'h0;
  localparam logic [127:0] KEY_SEQ = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_ALT = 128'hdeadbeef0123456789abcdeffedcba98;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [7:0]   sbox_tab [0:255];
  logic [127:0] exp_keys [0:15];
  int           exp_round = 0;
  int           transfers = 0;
  bit           chk_en = 0;
  bit           rdy_rand = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      sbox_tab[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // FIPS-197 KeyExpansion over the 44-word array.
  task automatic build_model(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++)
      exp_keys[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  initial begin
    key_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      key_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Compare process: every cycle, key order, value, stability and rcon range.
  initial begin : monitor
    bit           prev_v, prev_x;
    logic [127:0] prev_k;
    logic [3:0]   prev_i;
    prev_v = 0; prev_x = 0; prev_k = '0; prev_i = '0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("rcon_idx_range", 128'(dut.rcon_idx <= 4'd9), 128'h1);
        if (key_valid) begin
          check("round_order", 128'(round_idx), 128'(exp_round));
          check("round_key", round_key, exp_keys[round_idx]);
          if (prev_v && !prev_x) begin
            check("stall_key_stable", round_key, prev_k);
            check("stall_idx_stable", 128'(round_idx), 128'(prev_i));
          end
        end else if (prev_v && !prev_x) begin
          check("valid_dropped", 128'(key_valid), 128'h1);
        end
        prev_x = key_valid && key_ready;
        if (prev_x) begin
          exp_round++;
          transfers++;
        end
        prev_v = key_valid;
        prev_k = round_key;
        prev_i = round_idx;
      end else begin
        prev_v = 0;
        prev_x = 0;
      end
    end
  end

  task automatic run_exp(input logic [127:0] key, input bit chk_lat, input int inj_round,
                         input logic [127:0] inj_key);
    int n;
    bit seen, inj;
    build_model(key);
    @(negedge clk);
    check("idle_before_start", {125'h0, busy, key_valid, done}, 128'h0);
    exp_round = 0;
    transfers = 0;
    start  = 1'b1;
    key_in = key;
    n = 0; seen = 0; inj = 0;
    while (!seen && n < 400) begin
      @(negedge clk);
      n++;
      start  = 1'b0;
      key_in = ~key;
      if (inj_round >= 0 && !inj && key_valid && round_idx == 4'(inj_round)) begin
        start  = 1'b1;
        key_in = inj_key;
        inj    = 1;
      end
      if (n == 1) begin
        check("c1_valid", 128'(key_valid), 128'h1);
        check("c1_busy", 128'(busy), 128'h1);
        check("c1_round0", round_key, key);
      end
      if (done) seen = 1;
    end
    if (!seen) check("done_timeout", 128'(n), 128'h0);
    else if (chk_lat) check("done_cycle", 128'(n), 128'd12);
    check("transfer_count", 128'(transfers), 128'd11);
  endtask

  initial begin : main
    int n;
    build_sbox();
    n_rst  = 1'b0;
    start  = 1'b0;
    key_in = '0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {round_key[123:0], round_idx}, 128'h0);
    check("rst_flags", {125'h0, key_valid, busy, done}, 128'h0);
    n_rst  = 1'b1;
    chk_en = 1;

    check("sbox_00", 128'(sbox_tab[8'h00]), 128'h63);
    check("sbox_53", 128'(sbox_tab[8'h53]), 128'hed);
    build_model(KEY_A1);
    check("model_a1_r1", exp_keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("model_a1_r10", exp_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    build_model(KEY_Z);
    check("model_z_r1", exp_keys[1], 128'h62636363626363636263636362636363);
    check("model_z_r10", exp_keys[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    run_exp(KEY_A1, 1, -1, '0);

    rdy_rand = 1;
    run_exp(KEY_A1, 0, -1, '0);
    rdy_rand = 0;

    @(negedge clk);
    run_exp(KEY_Z, 1, -1, '0);
    run_exp(KEY_SEQ, 1, -1, '0);

    run_exp(KEY_A1, 1, 3, KEY_ALT);

    build_model(KEY_SEQ);
    @(negedge clk);
    exp_round = 0;
    start  = 1'b1;
    key_in = KEY_SEQ;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(key_valid && round_idx == 4'd5) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_round5", 128'(round_idx), 128'd5);
    chk_en = 0;
    #2;
    n_rst = 1'b0;
    #1;
    check("async_rst_key", round_key, 128'h0);
    check("async_rst_idx", 128'(round_idx), 128'h0);
    check("async_rst_flags", {125'h0, key_valid, busy, done}, 128'h0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {125'h0, key_valid, busy, done}, 128'h0);
    chk_en = 1;
    run_exp(KEY_ALT, 1, -1, '0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
